// File: rtl/rr_arbiter_dataless_pkg.sv
// Shared helpers for round-robin arbitrated control blocks: index width
// derivation and wrap-around index increment.
package rr_arbiter_dataless_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned incr_wrap(input int unsigned idx, input int unsigned size);
    return (idx + 1 >= size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_dataless_if.sv
// Handshake bundle between SIZE dataless requesters and one indexed output.
// master = requester/consumer environment, slave = the arbiter.
interface rr_arbiter_dataless_if
  import rr_arbiter_dataless_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int INDEX_WIDTH = clog2_min1(SIZE)
);
  logic [SIZE-1:0]        ins_valid;
  logic [SIZE-1:0]        ins_ready;
  logic                   outs_valid;
  logic                   outs_ready;
  logic [INDEX_WIDTH-1:0] index;

  modport master (
    output ins_valid, outs_ready,
    input  ins_ready, outs_valid, index
  );

  modport slave (
    input  ins_valid, outs_ready,
    output ins_ready, outs_valid, index
  );
endinterface

// File: rtl/rr_arbiter_dataless_priority_select.sv
// Rotating-priority select: first valid requester at or after ptr, wrapping,
// found by one priority encode over {valid, valid masked below ptr}.
module rr_priority_select
  import rr_arbiter_dataless_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int IW = clog2_min1(SIZE)
) (
  input  logic [SIZE-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [SIZE-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_valid
);
  logic [SIZE-1:0]   masked;
  logic [2*SIZE-1:0] dbl;
  int                first;

  always_comb begin
    masked = '0;
    for (int i = 0; i < SIZE; i++) masked[i] = valid[i] && (i >= int'(ptr));
  end

  // Masked copy sits in the low half so it wins; the full copy above it
  // supplies the wrapped-around candidates.
  assign dbl       = {valid, masked};
  assign any_valid = |valid;

  always_comb begin
    first = 0;
    for (int j = 2 * SIZE - 1; j >= 0; j--) begin
      if (dbl[j]) first = j;
    end
    if (first >= SIZE) first = first - SIZE;
    grant_idx = IW'(first);
    grant     = '0;
    for (int i = 0; i < SIZE; i++) grant[i] = any_valid && (i == first);
  end
endmodule

// File: rtl/rr_arbiter_dataless.sv
// Round-robin merge of SIZE dataless request channels into one registered
// output channel that carries the granted requester index.
module rr_arbiter_dataless
  import rr_arbiter_dataless_pkg::*;
#(
  parameter int SIZE = 2,
  localparam int INDEX_WIDTH = clog2_min1(SIZE)
) (
  input logic                 clk,
  input logic                 rst,
  rr_arbiter_dataless_if.slave bus
);
  logic                   slot_valid;
  logic [INDEX_WIDTH-1:0] slot_index;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [SIZE-1:0]        grant;
  logic [INDEX_WIDTH-1:0] grant_idx;
  logic                   any_valid;
  logic                   can_load;
  logic                   take;

  rr_priority_select #(.SIZE(SIZE)) u_sel (
    .valid     (bus.ins_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign can_load = ~slot_valid | bus.outs_ready;
  // rst gating keeps every ins_ready low for the whole reset interval.
  assign take          = rst & can_load & any_valid;
  assign bus.ins_ready = take ? grant : '0;

  assign bus.outs_valid = slot_valid;
  assign bus.index      = slot_index;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= 1'b0;
      slot_index <= '0;
      ptr        <= '0;
    end else if (take) begin
      slot_valid <= 1'b1;
      slot_index <= grant_idx;
      ptr        <= INDEX_WIDTH'(incr_wrap(32'(grant_idx), SIZE));
    end else if (bus.outs_ready) begin
      slot_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_dataless.sv
// Bench for rr_arbiter_dataless (SIZE=5): directed scenarios plus a random
// soak, all scored against a queue-based round-robin reference model.
module tb_rr_arbiter_dataless;
  import rr_arbiter_dataless_pkg::*;

  localparam int SIZE = 5;
  localparam int IW   = clog2_min1(SIZE);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter_dataless_if #(.SIZE(SIZE)) bus ();
  rr_arbiter_dataless #(.SIZE(SIZE)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #10 clk = ~clk;

  int              exp_q[$];
  int              mptr = 0;
  int              wait_cnt[SIZE];
  int              n_in = 0;
  int              n_out = 0;
  int              g_m;
  logic            can_m;
  logic [SIZE-1:0] exp_rdy_m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state is discarded the moment reset asserts.
  always @(negedge rst) begin
    exp_q.delete();
    mptr = 0;
    for (int i = 0; i < SIZE; i++) wait_cnt[i] = 0;
  end

  // Monitor: compares the output channel against the expected-token queue.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_outs_valid", int'(bus.outs_valid), 0);
      check("rst_index", int'(bus.index), 0);
    end else begin
      check("outs_valid", int'(bus.outs_valid), int'(exp_q.size() > 0));
      if (bus.outs_valid && exp_q.size() > 0) begin
        check("index", int'(bus.index), exp_q[0]);
        if (bus.outs_ready) begin
          void'(exp_q.pop_front());
          n_out++;
        end
      end
    end
  end

  // Reference model: round-robin scan from mptr; runs after the monitor.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      exp_q.delete();
      mptr = 0;
      for (int i = 0; i < SIZE; i++) wait_cnt[i] = 0;
      check("rst_ins_ready", int'(bus.ins_ready), 0);
    end else begin
      g_m = -1;
      exp_rdy_m = '0;
      for (int k = 0; k < SIZE; k++) begin
        if (g_m < 0 && bus.ins_valid[(mptr + k) % SIZE]) g_m = (mptr + k) % SIZE;
      end
      for (int i = 0; i < SIZE; i++) if (!bus.ins_valid[i]) wait_cnt[i] = 0;
      can_m = (exp_q.size() == 0) || bus.outs_ready;
      if (g_m >= 0 && can_m) begin
        exp_rdy_m[g_m] = 1'b1;
        check("fair_wait", int'(wait_cnt[g_m] < SIZE), 1);
        for (int i = 0; i < SIZE; i++) if (i != g_m && bus.ins_valid[i]) wait_cnt[i]++;
        wait_cnt[g_m] = 0;
        exp_q.push_back(g_m);
        mptr = (g_m + 1) % SIZE;
        n_in++;
      end
      check("ins_ready", int'(bus.ins_ready), int'(exp_rdy_m));
    end
  end

  logic [SIZE-1:0] acc;
  logic [SIZE-1:0] v;
  int              n_stim = 0;

  initial begin
    bus.ins_valid  = '1;
    bus.outs_ready = 1'b1;

    // Reset held with every requester asking.
    repeat (3) step();
    check("hold_rst_ins_ready", int'(bus.ins_ready), 0);
    check("hold_rst_outs_valid", int'(bus.outs_valid), 0);
    check("hold_rst_index", int'(bus.index), 0);

    // Cold start: requesters 1 and 2 ask, 1 wins from ptr=0.
    rst = 1'b1;
    bus.ins_valid = 5'b00110;
    #1 check("cold_ins_ready", int'(bus.ins_ready), 5'b00010);
    step();
    check("cold_outs_valid", int'(bus.outs_valid), 1);
    check("cold_index", int'(bus.index), 1);
    // ptr must now be 2: of {0,2}, requester 2 wins.
    bus.ins_valid = 5'b00101;
    #1 check("ptr_after_cold", int'(bus.ins_ready), 5'b00100);
    step();
    check("ptr_after_cold_index", int'(bus.index), 2);

    // Rotation from ptr=3 with every requester asking, no bubbles.
    bus.ins_valid = '1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("rot_valid", int'(bus.outs_valid), 1);
      check("rot_index", int'(bus.index), (3 + k) % SIZE);
    end

    // Backpressure on index 4; release must grant 0 in the same cycle.
    bus.outs_ready = 1'b0;
    #1 check("stall_ins_ready", int'(bus.ins_ready), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("stall_index", int'(bus.index), 4);
      check("stall_ins_ready", int'(bus.ins_ready), 0);
    end
    bus.outs_ready = 1'b1;
    #1 check("unstall_ins_ready", int'(bus.ins_ready), 5'b00001);
    step();
    check("unstall_index", int'(bus.index), 0);

    // Sparse requests and wrap: steer ptr to 4, then grant 1, then 4.
    bus.ins_valid = 5'b01000;
    step();
    check("sparse_idx3", int'(bus.index), 3);
    bus.ins_valid = 5'b00010;
    #1 check("sparse_rdy1", int'(bus.ins_ready), 5'b00010);
    step();
    check("sparse_idx1", int'(bus.index), 1);
    bus.ins_valid = 5'b10000;
    #1 check("sparse_rdy4", int'(bus.ins_ready), 5'b10000);
    step();
    check("sparse_idx4", int'(bus.index), 4);
    bus.ins_valid = '1;
    #1 check("wrap_ptr0", int'(bus.ins_ready), 5'b00001);
    step();

    // Mid-operation asynchronous reset with a stalled token for index 1.
    bus.ins_valid = 5'b00010;
    step();
    bus.ins_valid  = '0;
    bus.outs_ready = 1'b0;
    step();
    check("pre_rst_index", int'(bus.index), 1);
    check("pre_rst_valid", int'(bus.outs_valid), 1);
    #1 rst = 1'b0;
    #1 check("async_rst_valid", int'(bus.outs_valid), 0);
    check("async_rst_index", int'(bus.index), 0);
    #2;
    rst = 1'b1;
    bus.ins_valid  = '1;
    bus.outs_ready = 1'b1;
    #2 check("post_rst_rdy", int'(bus.ins_ready), 5'b00001);
    step();
    check("post_rst_index", int'(bus.index), 0);

    // Random soak: valid held until accepted, random backpressure.
    bus.ins_valid = '0;
    step();
    step();
    n_in  = 0;
    n_out = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = bus.ins_valid & bus.ins_ready;
      n_stim += $countones(acc);
      @(posedge clk);
      #1;
      v = bus.ins_valid & ~acc;
      for (int i = 0; i < SIZE; i++) if (!v[i] && $urandom_range(0, 2) == 0) v[i] = 1'b1;
      bus.ins_valid  = v;
      bus.outs_ready = ($urandom_range(0, 3) != 0);
    end
    // Let every pending requester drain, then empty the slot.
    for (int c = 0; c < 4 * SIZE; c++) begin
      @(negedge clk);
      acc = bus.ins_valid & bus.ins_ready;
      n_stim += $countones(acc);
      @(posedge clk);
      #1;
      bus.ins_valid  = bus.ins_valid & ~acc;
      bus.outs_ready = 1'b1;
    end
    step();
    step();
    check("soak_pending_valid", int'(bus.ins_valid), 0);
    check("soak_tokens_model", n_in, n_stim);
    check("soak_tokens_out", n_out, n_stim);
    check("soak_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
